// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard/stall controller.
// State encoding, default register-address width and the enable/flush bundle
// driven to the PC and the four segment registers.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } state_t;

    // Enable/flush bundle; flush dominates enable inside each segment register.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    // Build a bundle from an enable vector {pc,if_id,id_ex,ex_mem,mem_wb}
    // and a flush vector {if_id,id_ex,ex_mem,mem_wb}.
    function automatic ctrl_t make_ctrl(input logic [4:0] en, input logic [3:0] fl);
        ctrl_t c;
        c = ctrl_t'({en, fl});
        return c;
    endfunction

    // Everything held, everything bubbled: the cold-start pattern.
    localparam ctrl_t CTRL_START  = ctrl_t'(9'b00000_1111);
    // Front of the pipe frozen while MEM waits; a bubble is clocked into MEM/WB.
    localparam ctrl_t CTRL_STALL  = ctrl_t'(9'b00001_0001);
    // Redirect: keep fetching the new path, squash the two younger instructions.
    localparam ctrl_t CTRL_REDIR  = ctrl_t'(9'b11111_1100);
    // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
    localparam ctrl_t CTRL_LDUSE  = ctrl_t'(9'b00111_0100);
    // Normal flow.
    localparam ctrl_t CTRL_RUN    = ctrl_t'(9'b11111_0000);
    // Timeout: freeze everything, no bubbles.
    localparam ctrl_t CTRL_ERR    = ctrl_t'(9'b00000_0000);

endpackage

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: saturating event counter, cleared only by the async reset.
module pipe_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count increment events, sticking at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for the five-stage pipeline.
// Drives PC / IF-ID / ID-EX / EX-MEM / MEM-WB enable and flush controls for
// load-use stalls, redirect flushes and data-memory waits, and latches a
// memory-timeout error. Outputs are Mealy functions of state and inputs.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall_cnt / flush_cnt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int WAIT_MAX   = 15,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  timeout_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              lu_s;
    logic              ms_s;
    ctrl_t             run_ctrl_s;
    ctrl_t             ctrl_s;

    // Hazard detection: load-use against the ID sources, and a memory not ready.
    always_comb begin
        lu_s = ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}}) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));
        ms_s = mem_req && !mem_ready;
    end

    // Priority rules for a running pipeline: memory stall, redirect, load-use, normal.
    always_comb begin
        run_ctrl_s = CTRL_RUN;
        if (ms_s) begin
            run_ctrl_s = CTRL_STALL;
        end else if (ex_redirect) begin
            // A simultaneous load-use is moot: its consumer is being squashed.
            run_ctrl_s = CTRL_REDIR;
        end else if (lu_s) begin
            run_ctrl_s = CTRL_LDUSE;
        end else begin
            run_ctrl_s = CTRL_RUN;
        end
    end

    // Next-state, wait counter and output selection.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        ctrl_s         = CTRL_START;
        case (state_r)
            START: begin
                ctrl_s         = CTRL_START;
                state_nxt_s    = RUN;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
            RUN: begin
                ctrl_s = run_ctrl_s;
                if (ms_s) begin
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Completion cycle behaves as a normal RUN cycle.
                    ctrl_s      = run_ctrl_s;
                    state_nxt_s = RUN;
                end else begin
                    ctrl_s = CTRL_STALL;
                    if (wait_cnt_r != WAIT_LIMIT) begin
                        wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r;
                    end
                    if (wait_cnt_nxt_s == WAIT_LIMIT) begin
                        state_nxt_s = ERR;
                    end else begin
                        state_nxt_s = MEM_WAIT;
                    end
                end
            end
            ERR: begin
                ctrl_s      = CTRL_ERR;
                state_nxt_s = ERR;
            end
            default: begin
                ctrl_s         = CTRL_START;
                state_nxt_s    = START;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State and wait-counter registers; reset parks the block in START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= START;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign pc_en        = ctrl_s.pc_en;
    assign if_id_en     = ctrl_s.if_id_en;
    assign id_ex_en     = ctrl_s.id_ex_en;
    assign ex_mem_en    = ctrl_s.ex_mem_en;
    assign mem_wb_en    = ctrl_s.mem_wb_en;
    assign if_id_flush  = ctrl_s.if_id_flush;
    assign id_ex_flush  = ctrl_s.id_ex_flush;
    assign ex_mem_flush = ctrl_s.ex_mem_flush;
    assign mem_wb_flush = ctrl_s.mem_wb_flush;
    assign timeout_err  = (state_r == ERR);

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc_s;
    logic flush_inc_s;

    // Event strobes: front-end held, or a redirect actually flushing.
    always_comb begin
        stall_inc_s = ((state_r == RUN) || (state_r == MEM_WAIT)) && !ctrl_s.pc_en;
        flush_inc_s = ((state_r == RUN) || ((state_r == MEM_WAIT) && mem_ready)) &&
                      !ms_s && ex_redirect;
    end

    pipe_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    pipe_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized bench for pipe_ctrl against a
// behavioural model that counts consecutive stalled memory cycles.
module tb_pipe_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, timeout_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl #(.REG_ADDR_W(5), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .timeout_err(timeout_err)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [8:0] obs_b;
    assign obs_b = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: has the first post-reset edge happened, has the timeout
    // fired, how many consecutive stalled memory cycles so far, perf tallies.
    bit m_started;
    bit m_dead;
    int m_run;
    int m_stall_cnt;
    int m_flush_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_dead      = 1'b0;
        m_run       = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // Entered at posedge+1 with inputs already driven; checks mid-cycle,
    // then advances the model across the next rising edge.
    task automatic step(input string tag);
        logic [8:0] exp_b;
        bit lu;
        bit st;
        #2;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        st = 1'b0;
        if (!rst || !m_started) begin
            exp_b = 9'b00000_1111;
        end else if (m_dead) begin
            exp_b = 9'b00000_0000;
        end else begin
            // Once a wait has begun only mem_ready ends it.
            st = (m_run > 0) ? !mem_ready : (mem_req && !mem_ready);
            if (st)               exp_b = 9'b00001_0001;
            else if (ex_redirect) exp_b = 9'b11111_1100;
            else if (lu)          exp_b = 9'b00111_0100;
            else                  exp_b = 9'b11111_0000;
        end
        check_eq(tag, 32'(obs_b), 32'(exp_b));
        check_eq({tag, "/timeout"}, 32'(timeout_err), 32'(m_dead));
`ifdef PIPE_CTRL_PERF_EN
        check_eq({tag, "/stall_cnt"}, stall_cnt, 32'(m_stall_cnt));
        check_eq({tag, "/flush_cnt"}, flush_cnt, 32'(m_flush_cnt));
`endif
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_dead) begin
            if (st) begin
                m_run++;
                m_stall_cnt++;
                if (m_run == WAIT_MAX + 1) m_dead = 1'b1;
            end else begin
                m_run = 0;
                if (!ex_redirect && lu) m_stall_cnt++;
                if (ex_redirect) m_flush_cnt++;
            end
        end
        #1;
    endtask

    // Assert reset between edges and confirm START outputs appear at once.
    task automatic async_reset(input string tag);
        #1;
        rst = 1'b0;
        #1;
        check_eq({tag, "/bundle"}, 32'(obs_b), 32'(9'b00000_1111));
        check_eq({tag, "/timeout"}, 32'(timeout_err), 32'd0);
        model_reset();
        idle();
        step({tag, "/held"});
        rst = 1'b1;
        step({tag, "/start"});
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b0;
        step("reset");
        step("reset_hold");
        rst = 1'b1;
        step("release_start");
        step("run_idle");

        // Load-use on rs1: one bubble, then the load has moved on.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        step("lu_rs1");
        ex_mem_read = 1'b0;
        step("lu_drop");
        // Destination x0 never creates a hazard.
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        step("lu_x0");
        // Matching register but the source is not read.
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b0;
        step("lu_unused");
        id_rs2_used = 1'b1;
        step("lu_rs2");
        // Redirect together with load-use: the redirect wins.
        idle(); ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        step("redir_lu");
        idle();
        step("after_redir");

        // Memory wait: not ready for 3 cycles, then completes.
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) step("mem_wait");
        mem_ready = 1'b1;
        step("mem_ready");
        // Ready in the request cycle: no stall.
        step("mem_no_stall");
        idle();
        step("mem_done");

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 4) == 0);
            mem_req     = 1'($urandom_range(0, 1));
            mem_ready   = ($urandom_range(0, 3) != 0);
            step("random");
        end

        // Async reset in the middle of a memory wait.
        idle();
        async_reset("rst_pre");
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (5) step("wait_then_rst");
        async_reset("rst_mid_wait");

        // Timeout: 1 RUN cycle + WAIT_MAX MEM_WAIT cycles, then ERR.
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (WAIT_MAX + 1) step("to_stall");
        check_eq("timeout_raised", 32'(timeout_err), 32'd1);
        repeat (3) step("to_err");
        idle(); ex_redirect = 1'b1;
        step("err_sticky");
        check_eq("err_still_set", 32'(timeout_err), 32'd1);
        async_reset("rst_from_err");
        step("after_err_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
